// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the EX-stage branch redirect unit: redirect FSM
// states, the conditional-branch funct3 encodings shared with the branch
// comparator, and the default datapath width.
package branch_redirect_unit_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } bru_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/bru_target_calc.sv
// Combinational control-transfer target generation.
// Branch/JAL: PC + IMM. JALR: (RS1 + IMM) with bit 0 cleared.
// Sums wrap modulo 2^XLEN. A target with bit 1 set is flagged misaligned.
module bru_target_calc #(
    parameter int XLEN = 32
) (
    input  logic            is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] rs1_sum;

    assign pc_sum     = ex_pc + ex_imm;
    assign rs1_sum    = ex_rs1 + ex_imm;
    assign target     = is_jalr ? {rs1_sum[XLEN-1:1], 1'b0} : pc_sum;
    assign misaligned = target[1];

endmodule

// File: rtl/branch_redirect_unit.sv
// EX-stage branch redirect unit. Resolves taken branches, JAL and JALR,
// issues a registered redirect to fetch over a valid/ready handshake,
// pulses the IF/ID and ID/EX flushes and stalls the front end while the
// redirect is outstanding. Misaligned targets raise a one-cycle exception
// pulse instead of redirecting.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            EX_VALID,
    input  logic            IS_BRANCH,
    input  logic            IS_JAL,
    input  logic            IS_JALR,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] EX_PC,
    input  logic [XLEN-1:0] EX_IMM,
    input  logic [XLEN-1:0] EX_RS1,
    input  logic            IF_READY,
    output logic            REDIRECT_VALID,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic            FLUSH_IFID,
    output logic            FLUSH_IDEX,
    output logic            FE_STALL,
    output logic            TARGET_MISALIGNED,
    output logic [31:0]     TAKEN_COUNT,
    output logic [31:0]     STALL_COUNT
);

    bru_state_t      state;
    logic            ctl_event;
    logic [XLEN-1:0] target;
    logic            misaligned;

    assign ctl_event = EX_VALID & ((IS_BRANCH & BRANCH_TAKEN) | IS_JAL | IS_JALR);

    bru_target_calc #(.XLEN(XLEN)) u_target_calc (
        .is_jalr    (IS_JALR),
        .ex_pc      (EX_PC),
        .ex_imm     (EX_IMM),
        .ex_rs1     (EX_RS1),
        .target     (target),
        .misaligned (misaligned)
    );

    // Redirect FSM with registered redirect, flush, stall and exception outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state             <= ST_IDLE;
            REDIRECT_VALID    <= 1'b0;
            REDIRECT_PC       <= '0;
            FLUSH_IFID        <= 1'b0;
            FLUSH_IDEX        <= 1'b0;
            FE_STALL          <= 1'b0;
            TARGET_MISALIGNED <= 1'b0;
        end else begin
            FLUSH_IFID        <= 1'b0;
            FLUSH_IDEX        <= 1'b0;
            TARGET_MISALIGNED <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctl_event) begin
                        FLUSH_IFID <= 1'b1;
                        FLUSH_IDEX <= 1'b1;
                        if (misaligned) begin
                            TARGET_MISALIGNED <= 1'b1;
                        end else begin
                            REDIRECT_PC    <= target;
                            REDIRECT_VALID <= 1'b1;
                            FE_STALL       <= 1'b1;
                            state          <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    // EX holds only the flushed bubble here; its inputs are ignored
                    if (IF_READY) begin
                        REDIRECT_VALID <= 1'b0;
                        FE_STALL       <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRU_STATS_EN
    // Saturating counts of accepted redirects and fetch-backpressure cycles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TAKEN_COUNT <= '0;
            STALL_COUNT <= '0;
        end else begin
            if (state == ST_IDLE && ctl_event && !misaligned && TAKEN_COUNT != 32'hFFFF_FFFF) begin
                TAKEN_COUNT <= TAKEN_COUNT + 32'd1;
            end
            if (state == ST_PENDING && !IF_READY && STALL_COUNT != 32'hFFFF_FFFF) begin
                STALL_COUNT <= STALL_COUNT + 32'd1;
            end
        end
    end
`else
    assign TAKEN_COUNT = '0;
    assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed testbench for branch_redirect_unit with hand-computed expectations.
// Counter expectations follow BRU_STATS_EN when it is defined for the build.
module tb_branch_redirect_unit;

    logic        CLK;
    logic        RESET;
    logic        EX_VALID;
    logic        IS_BRANCH;
    logic        IS_JAL;
    logic        IS_JALR;
    logic        BRANCH_TAKEN;
    logic [31:0] EX_PC;
    logic [31:0] EX_IMM;
    logic [31:0] EX_RS1;
    logic        IF_READY;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        FLUSH_IFID;
    logic        FLUSH_IDEX;
    logic        FE_STALL;
    logic        TARGET_MISALIGNED;
    logic [31:0] TAKEN_COUNT;
    logic [31:0] STALL_COUNT;

    int checks;
    int failures;

    branch_redirect_unit #(.XLEN(32)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .EX_VALID          (EX_VALID),
        .IS_BRANCH         (IS_BRANCH),
        .IS_JAL            (IS_JAL),
        .IS_JALR           (IS_JALR),
        .BRANCH_TAKEN      (BRANCH_TAKEN),
        .EX_PC             (EX_PC),
        .EX_IMM            (EX_IMM),
        .EX_RS1            (EX_RS1),
        .IF_READY          (IF_READY),
        .REDIRECT_VALID    (REDIRECT_VALID),
        .REDIRECT_PC       (REDIRECT_PC),
        .FLUSH_IFID        (FLUSH_IFID),
        .FLUSH_IDEX        (FLUSH_IDEX),
        .FE_STALL          (FE_STALL),
        .TARGET_MISALIGNED (TARGET_MISALIGNED),
        .TAKEN_COUNT       (TAKEN_COUNT),
        .STALL_COUNT       (STALL_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        EX_VALID     = 1'b0;
        IS_BRANCH    = 1'b0;
        IS_JAL       = 1'b0;
        IS_JALR      = 1'b0;
        BRANCH_TAKEN = 1'b0;
        EX_PC        = '0;
        EX_IMM       = '0;
        EX_RS1       = '0;
    endtask

    task automatic set_ex(input logic br, input logic tk, input logic jal, input logic jalr,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        EX_VALID     = 1'b1;
        IS_BRANCH    = br;
        BRANCH_TAKEN = tk;
        IS_JAL       = jal;
        IS_JALR      = jalr;
        EX_PC        = pc;
        EX_IMM       = imm;
        EX_RS1       = rs1;
    endtask

    // valid, stall, ifid flush, idex flush, misaligned packed as a 5-bit vector
    function automatic logic [31:0] ctl_vec();
        return {27'd0, REDIRECT_VALID, FE_STALL, FLUSH_IFID, FLUSH_IDEX, TARGET_MISALIGNED};
    endfunction

    task automatic check_counts(input string tag, input logic [31:0] taken, input logic [31:0] stall);
`ifdef BRU_STATS_EN
        check({tag, "_taken"}, TAKEN_COUNT, taken);
        check({tag, "_stall"}, STALL_COUNT, stall);
`else
        check({tag, "_taken"}, TAKEN_COUNT, 32'd0);
        check({tag, "_stall"}, STALL_COUNT, 32'd0);
        if (taken == stall) begin end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_ex();
        IF_READY = 1'b0;
        RESET    = 1'b1;
        tick();
        tick();
        check("reset_ctl", ctl_vec(), 32'h0);
        check("reset_pc", REDIRECT_PC, 32'h0);
        check_counts("reset", 32'd0, 32'd0);
        RESET = 1'b0;
        tick();

        // Taken branch, fetch ready immediately
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
        IF_READY = 1'b1;
        tick();
        clear_ex();
        check("br_ctl", ctl_vec(), 32'b11110);
        check("br_pc", REDIRECT_PC, 32'h120);
        tick();
        check("br_idle", ctl_vec(), 32'h0);

        // JALR clears bit 0 of the sum
        set_ex(1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'hFFFF_FFFE, 32'h2003);
        tick();
        clear_ex();
        check("jalr_ctl", ctl_vec(), 32'b11110);
        check("jalr_pc", REDIRECT_PC, 32'h2000);
        tick();
        check("jalr_idle", ctl_vec(), 32'h0);

        // JAL to 0x400 with three cycles of fetch backpressure
        IF_READY = 1'b0;
        set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h100, 32'h0);
        tick();
        // a spurious event during PENDING must be ignored
        set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h8, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_ctl%0d", i), ctl_vec(), (i == 0) ? 32'b11110 : 32'b11000);
            check($sformatf("bp_pc%0d", i), REDIRECT_PC, 32'h400);
            if (i == 3) begin
                IF_READY = 1'b1;
                clear_ex();
            end
            tick();
        end
        check("bp_idle", ctl_vec(), 32'h0);
        check("bp_pc_hold", REDIRECT_PC, 32'h400);
        check_counts("bp", 32'd3, 32'd3);

        // Not-taken branch and bubble with JAL flag produce nothing
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
        tick();
        check("nt_ctl", ctl_vec(), 32'h0);
        set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
        EX_VALID = 1'b0;
        tick();
        clear_ex();
        check("bubble_ctl", ctl_vec(), 32'h0);

        // Misaligned branch target 0x106
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h6, 32'h0);
        tick();
        clear_ex();
        check("mis_ctl", ctl_vec(), 32'b00111);
        tick();
        check("mis_after", ctl_vec(), 32'h0);
        check_counts("mis", 32'd3, 32'd3);

        // Target wraps modulo 2^32
        set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
        tick();
        clear_ex();
        check("wrap_ctl", ctl_vec(), 32'b11110);
        check("wrap_pc", REDIRECT_PC, 32'h10);
        tick();
        check("wrap_idle", ctl_vec(), 32'h0);
        check_counts("wrap", 32'd4, 32'd3);

        // Asynchronous reset in the middle of PENDING
        IF_READY = 1'b0;
        set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
        tick();
        clear_ex();
        check("rstp_pend", ctl_vec(), 32'b11110);
        #2;
        RESET = 1'b1;
        #1;
        check("rstp_ctl", ctl_vec(), 32'h0);
        check("rstp_pc", REDIRECT_PC, 32'h0);
        check_counts("rstp", 32'd0, 32'd0);
        RESET    = 1'b0;
        IF_READY = 1'b1;
        tick();
        check("rstp_idle", ctl_vec(), 32'h0);
        tick();
        check("rstp_idle2", ctl_vec(), 32'h0);
        check_counts("rstp_end", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
